// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg: shared CSR addresses, HPM event selector sizing and event-register layout
package cpu_params_pkg;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;

   function automatic int bit_size(input int v);
      int n = 1;
      for (int i = 1; i < 32; i++) if ((v >> i) != 0) n = i + 1;
      return n;
   endfunction

   // The selector field is sized for the default event count; banks built
   // with more events than 2**EV_SEL_SZ need this constant raised.
   localparam int HPM_NUM_EVENTS = 24;
   localparam int EV_SEL_SZ      = bit_size(HPM_NUM_EVENTS - 1);

   typedef struct packed {
      logic                 of;
      logic [EV_SEL_SZ-1:0] sel;
   } hpm_event_t;
endpackage

// File: rtl/hpm_counter.sv
// hpm_counter: one HPM slice - counter, event selector, sticky overflow flag
//   i_clk, i_rst_n  clock, async active-low reset
//   i_events        per-cycle event pulses, selected by SEL
//   i_inhibit       this counter's mcountinhibit bit
//   i_wr_ev/lo/hi   CSR write strobes for mhpmevent / counter lo / counter hi
//   i_wdata         CSR write data
//   o_cnt           counter zero-extended to 64 bits
//   o_ev            stored {OF, SEL}
module hpm_counter
   import cpu_params_pkg::*;
#(
   parameter int CNT_SZ     = 64,
   parameter int NUM_EVENTS = HPM_NUM_EVENTS
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NUM_EVENTS-1:0] i_events,
   input  logic                  i_inhibit,
   input  logic                  i_wr_ev,
   input  logic                  i_wr_lo,
   input  logic                  i_wr_hi,
   input  logic [31:0]           i_wdata,
   output logic [63:0]           o_cnt,
   output hpm_event_t            o_ev
);
   logic [CNT_SZ-1:0]    r_cnt;
   hpm_event_t           r_ev;
   logic                 w_inc;
   logic                 w_wrap;
   logic [63:0]          w_wr_val;
   logic [EV_SEL_SZ-1:0] w_sel;

   assign o_cnt    = 64'(r_cnt);
   assign o_ev     = r_ev;
   assign w_sel    = i_wdata[EV_SEL_SZ-1:0];
   // a counter write this cycle suppresses the increment
   assign w_inc    = (r_ev.sel != '0) && i_events[r_ev.sel] && !i_inhibit && !i_wr_lo && !i_wr_hi;
   assign w_wrap   = w_inc && (&r_cnt);
   // bits at or above CNT_SZ are dropped by the truncation below
   assign w_wr_val = i_wr_hi ? {i_wdata, o_cnt[31:0]} : {o_cnt[63:32], i_wdata};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_ev  <= '0;
      end else begin
         if (i_wr_lo || i_wr_hi) r_cnt <= w_wr_val[CNT_SZ-1:0];
         else if (w_inc) r_cnt <= r_cnt + CNT_SZ'(1);
         if (i_wr_ev) begin
            r_ev.of  <= i_wdata[31];
            r_ev.sel <= (32'(w_sel) < NUM_EVENTS) ? w_sel : '0;
         end else if (w_wrap) r_ev.of <= 1'b1;
      end
   end
endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mhpmcounter/mhpmevent bank with mcountinhibit, overflow irq and registered CSR reads
//   clk_in, reset_n_in        clock, async active-low reset
//   events_in                 per-cycle event pulses (bit 0 never counts)
//   csr_wr_in/waddr/wdata     CSR write port
//   csr_rd_in/raddr           CSR read request
//   csr_rdata/rd_valid/rd_hit registered read response, one cycle later
//   inhibit_cy_out/ir_out     mcountinhibit bits 0 and 2
//   ovf_irq_out               OR of all overflow flags
module hpm_counter_bank
   import cpu_params_pkg::*;
#(
   parameter int          NUM_CNT       = 4,
   parameter int          NUM_EVENTS    = HPM_NUM_EVENTS,
   parameter int          CNT_SZ        = 64,
   parameter int          INHIBIT_FIXED = 0,
   parameter logic [31:0] INHIBIT_BITS  = 32'h0
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic [NUM_EVENTS-1:0] events_in,
   input  logic                  csr_wr_in,
   input  logic [11:0]           csr_waddr_in,
   input  logic [31:0]           csr_wdata_in,
   input  logic                  csr_rd_in,
   input  logic [11:0]           csr_raddr_in,
   output logic [31:0]           csr_rdata_out,
   output logic                  csr_rd_valid_out,
   output logic                  csr_rd_hit_out,
   output logic                  inhibit_cy_out,
   output logic                  inhibit_ir_out,
   output logic                  ovf_irq_out
);
   // writable inhibit bits: CY, IR and one per implemented counter
   localparam logic [31:0] INH_MASK = (((32'd1 << NUM_CNT) - 32'd1) << 3) | 32'h5;

   logic [31:0]        r_inhibit;
   logic [31:0]        w_inhibit;
   logic [NUM_CNT-1:0] w_of;
   logic [63:0]        w_cnt [NUM_CNT];
   hpm_event_t         w_ev  [NUM_CNT];
   logic [31:0]        w_rdata;
   logic               w_hit;
   logic [31:0]        r_rdata;
   logic               r_rd_valid;
   logic               r_rd_hit;

   assign w_inhibit        = (INHIBIT_FIXED != 0) ? (INHIBIT_BITS & INH_MASK) : r_inhibit;
   assign inhibit_cy_out   = w_inhibit[0];
   assign inhibit_ir_out   = w_inhibit[2];
   assign ovf_irq_out      = |w_of;
   assign csr_rdata_out    = r_rdata;
   assign csr_rd_valid_out = r_rd_valid;
   assign csr_rd_hit_out   = r_rd_hit;

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
      hpm_counter #(.CNT_SZ(CNT_SZ), .NUM_EVENTS(NUM_EVENTS)) u_cnt (
         .i_clk    (clk_in),
         .i_rst_n  (reset_n_in),
         .i_events (events_in),
         .i_inhibit(w_inhibit[3+k]),
         .i_wr_ev  (csr_wr_in && csr_waddr_in == 12'(CSR_MHPMEVENT3 + k)),
         .i_wr_lo  (csr_wr_in && csr_waddr_in == 12'(CSR_MHPMCOUNTER3 + k)),
         .i_wr_hi  (csr_wr_in && csr_waddr_in == 12'(CSR_MHPMCOUNTER3H + k)),
         .i_wdata  (csr_wdata_in),
         .o_cnt    (w_cnt[k]),
         .o_ev     (w_ev[k])
      );
      assign w_of[k] = w_ev[k].of;
   end

   always_comb begin
      w_rdata = '0;
      w_hit   = 1'b0;
      if (csr_raddr_in == CSR_MCOUNTINHIBIT) begin
         w_hit   = 1'b1;
         w_rdata = w_inhibit;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
         if (csr_raddr_in == 12'(CSR_MHPMEVENT3 + i)) begin
            w_hit   = 1'b1;
            w_rdata = {w_ev[i].of, 31'(w_ev[i].sel)};
         end
         if (csr_raddr_in == 12'(CSR_MHPMCOUNTER3 + i)) begin
            w_hit   = 1'b1;
            w_rdata = w_cnt[i][31:0];
         end
         if (csr_raddr_in == 12'(CSR_MHPMCOUNTER3H + i)) begin
            w_hit   = 1'b1;
            w_rdata = w_cnt[i][63:32];
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) r_inhibit <= '0;
      else if (INHIBIT_FIXED == 0 && csr_wr_in && csr_waddr_in == CSR_MCOUNTINHIBIT) r_inhibit <= csr_wdata_in & INH_MASK;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_rdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= csr_rd_in;
         if (csr_rd_in) begin
            r_rdata  <= w_rdata;
            r_rd_hit <= w_hit;
         end
      end
   end
endmodule
